load_comp_arbiter: RTL and testbench

LOAD_COMP_ARBITER -- requirements
Module: load_comp_arbiter

---
 rtl/load_comp_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_load_comp_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_comp_arbiter.sv
// Load-completion arbiter: buffers load results from the LSQ forwarding path and
// the data-memory path in two small FIFOs and offers one result per cycle to the
// MEM/complete pipeline register, round-robin when both sources have entries.
module load_comp_arbiter #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          lsq_valid,
    input  logic [DW-1:0] lsq_data,
    input  logic [DW-1:0] lsq_pc,
    output logic          lsq_ready,
    input  logic          mem_valid,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_pc,
    output logic          mem_ready,
    output logic          out_valid,
    output logic          out_from_lsq,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] out_pc,
    input  logic          out_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Queue storage (no reset: pointers and counts define what is valid)
    logic [DW-1:0] lsq_data_q [DEPTH];
    logic [DW-1:0] lsq_pc_q   [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];
    logic [DW-1:0] mem_pc_q   [DEPTH];

    logic [AW-1:0] lsq_rptr_q, lsq_rptr_d, lsq_wptr_q, lsq_wptr_d;
    logic [AW-1:0] mem_rptr_q, mem_rptr_d, mem_wptr_q, mem_wptr_d;
    logic [CW-1:0] lsq_count_q, lsq_count_d, mem_count_q, mem_count_d;

    // 1 = LSQ queue was granted at the last pop
    logic last_lsq_q, last_lsq_d;
    // Grant frozen while the offered result is stalled by out_ready=0
    logic hold_q, hold_d, hold_lsq_q, hold_lsq_d;

    logic lsq_ne, mem_ne, grant_lsq;
    logic lsq_push, mem_push, lsq_pop, mem_pop, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign lsq_ne    = (lsq_count_q != '0);
    assign mem_ne    = (mem_count_q != '0);
    assign lsq_ready = (lsq_count_q < CW'(DEPTH));
    assign mem_ready = (mem_count_q < CW'(DEPTH));
    assign out_valid = lsq_ne || mem_ne;

    assign lsq_push = lsq_valid && lsq_ready;
    assign mem_push = mem_valid && mem_ready;
    assign do_pop   = out_valid && out_ready;
    assign lsq_pop  = do_pop && grant_lsq;
    assign mem_pop  = do_pop && !grant_lsq;

    // Grant selection: held grant, else round-robin on a tie, else the non-empty queue
    always_comb begin
        grant_lsq = 1'b0;
        if (hold_q) begin
            grant_lsq = hold_lsq_q;
        end else if (lsq_ne && mem_ne) begin
            grant_lsq = !last_lsq_q;
        end else begin
            grant_lsq = lsq_ne;
        end
    end

    // Output mux from the granted queue head; zero when nothing is offered
    always_comb begin
        out_from_lsq = 1'b0;
        out_data     = '0;
        out_pc       = '0;
        if (out_valid) begin
            out_from_lsq = grant_lsq;
            if (grant_lsq) begin
                out_data = lsq_data_q[lsq_rptr_q];
                out_pc   = lsq_pc_q[lsq_rptr_q];
            end else begin
                out_data = mem_data_q[mem_rptr_q];
                out_pc   = mem_pc_q[mem_rptr_q];
            end
        end
    end

    // LSQ queue pointer/count next state; flush overrides push and pop
    always_comb begin
        lsq_rptr_d  = lsq_rptr_q;
        lsq_wptr_d  = lsq_wptr_q;
        lsq_count_d = lsq_count_q;
        if (flush) begin
            lsq_rptr_d  = '0;
            lsq_wptr_d  = '0;
            lsq_count_d = '0;
        end else begin
            if (lsq_push) lsq_wptr_d = ptr_inc(lsq_wptr_q);
            if (lsq_pop)  lsq_rptr_d = ptr_inc(lsq_rptr_q);
            if (lsq_push && !lsq_pop) begin
                lsq_count_d = lsq_count_q + 1'b1;
            end else if (!lsq_push && lsq_pop) begin
                lsq_count_d = lsq_count_q - 1'b1;
            end
        end
    end

    // MEM queue pointer/count next state; flush overrides push and pop
    always_comb begin
        mem_rptr_d  = mem_rptr_q;
        mem_wptr_d  = mem_wptr_q;
        mem_count_d = mem_count_q;
        if (flush) begin
            mem_rptr_d  = '0;
            mem_wptr_d  = '0;
            mem_count_d = '0;
        end else begin
            if (mem_push) mem_wptr_d = ptr_inc(mem_wptr_q);
            if (mem_pop)  mem_rptr_d = ptr_inc(mem_rptr_q);
            if (mem_push && !mem_pop) begin
                mem_count_d = mem_count_q + 1'b1;
            end else if (!mem_push && mem_pop) begin
                mem_count_d = mem_count_q - 1'b1;
            end
        end
    end

    // Arbitration state: last grant moves only on a pop, hold tracks a stall
    always_comb begin
        last_lsq_d = last_lsq_q;
        hold_d     = 1'b0;
        hold_lsq_d = hold_lsq_q;
        if (flush) begin
            last_lsq_d = 1'b0;
        end else begin
            if (do_pop) last_lsq_d = grant_lsq;
            if (out_valid && !out_ready) begin
                hold_d     = 1'b1;
                hold_lsq_d = grant_lsq;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsq_rptr_q  <= '0;
            lsq_wptr_q  <= '0;
            lsq_count_q <= '0;
            mem_rptr_q  <= '0;
            mem_wptr_q  <= '0;
            mem_count_q <= '0;
            last_lsq_q  <= 1'b0;
            hold_q      <= 1'b0;
            hold_lsq_q  <= 1'b0;
        end else begin
            lsq_rptr_q  <= lsq_rptr_d;
            lsq_wptr_q  <= lsq_wptr_d;
            lsq_count_q <= lsq_count_d;
            mem_rptr_q  <= mem_rptr_d;
            mem_wptr_q  <= mem_wptr_d;
            mem_count_q <= mem_count_d;
            last_lsq_q  <= last_lsq_d;
            hold_q      <= hold_d;
            hold_lsq_q  <= hold_lsq_d;
        end
    end

    // Queue payload writes on push
    always_ff @(posedge clk) begin
        if (lsq_push) begin
            lsq_data_q[lsq_wptr_q] <= lsq_data;
            lsq_pc_q[lsq_wptr_q]   <= lsq_pc;
        end
        if (mem_push) begin
            mem_data_q[mem_wptr_q] <= mem_data;
            mem_pc_q[mem_wptr_q]   <= mem_pc;
        end
    end

endmodule

// File: tb/tb_load_comp_arbiter.sv
// Self-checking bench for load_comp_arbiter: directed scenarios plus a random
// push/pop/flush run checked against a per-source queue scoreboard.
module tb_load_comp_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk, rst, flush;
    logic          lsq_valid, mem_valid, out_ready;
    logic [DW-1:0] lsq_data, lsq_pc, mem_data, mem_pc;
    logic          lsq_ready, mem_ready, out_valid, out_from_lsq;
    logic [DW-1:0] out_data, out_pc;

    int n_checks = 0;
    int n_errors = 0;

    load_comp_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .lsq_valid    (lsq_valid),
        .lsq_data     (lsq_data),
        .lsq_pc       (lsq_pc),
        .lsq_ready    (lsq_ready),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data),
        .mem_pc       (mem_pc),
        .mem_ready    (mem_ready),
        .out_valid    (out_valid),
        .out_from_lsq (out_from_lsq),
        .out_data     (out_data),
        .out_pc       (out_pc),
        .out_ready    (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lsq_valid = 1'b0;
        mem_valid = 1'b0;
        flush     = 1'b0;
    endtask

    logic [63:0] lq[$];
    logic [63:0] mq[$];
    logic [63:0] exp_head;
    logic        pop_l, pop_m, push_l, push_m;
    int          wait_l, wait_m;
    logic [31:0] pc_ctr;

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        lsq_valid = 1'b0; lsq_data = '0; lsq_pc = '0;
        mem_valid = 1'b0; mem_data = '0; mem_pc = '0;
        #1 rst = 1'b1;
        #1;
        // Reset state, before any clock edge
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_lsq_ready", lsq_ready, 1);
        check_val("rst_mem_ready", mem_ready, 1);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_pc", out_pc, 0);
        step();
        #3 rst = 1'b0;

        // Single LSQ result
        out_ready = 1'b1;
        lsq_valid = 1'b1; lsq_data = 32'hAAAA_0001; lsq_pc = 32'h100;
        step();
        clear_inputs();
        check_val("single_valid", out_valid, 1);
        check_val("single_from_lsq", out_from_lsq, 1);
        check_val("single_data", out_data, 32'hAAAA_0001);
        check_val("single_pc", out_pc, 32'h100);
        step();
        check_val("single_drained", out_valid, 0);

        // Flush so the LSQ queue wins the next tie
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Tie: alternate starting with LSQ
        lsq_valid = 1'b1; lsq_pc = 32'h10; lsq_data = 32'hD10;
        mem_valid = 1'b1; mem_pc = 32'h20; mem_data = 32'hD20;
        step();
        check_val("tie_0_pc", out_pc, 32'h10);
        lsq_pc = 32'h14; lsq_data = 32'hD14;
        mem_pc = 32'h24; mem_data = 32'hD24;
        step();
        clear_inputs();
        check_val("tie_1_pc", out_pc, 32'h20);
        check_val("tie_1_from_lsq", out_from_lsq, 0);
        step();
        check_val("tie_2_pc", out_pc, 32'h14);
        step();
        check_val("tie_3_pc", out_pc, 32'h24);
        check_val("tie_3_data", out_data, 32'hD24);
        step();
        check_val("tie_drained", out_valid, 0);

        // Backpressure on MEM, plus an LSQ arrival that must not steal the grant
        out_ready = 1'b0;
        mem_valid = 1'b1; mem_pc = 32'h30; mem_data = 32'hD30;
        step();
        check_val("bp_first_pc", out_pc, 32'h30);
        mem_pc = 32'h34; mem_data = 32'hD34;
        lsq_valid = 1'b1; lsq_pc = 32'h40; lsq_data = 32'hD40;
        step();
        lsq_valid = 1'b0;
        check_val("bp_mem_full", mem_ready, 0);
        check_val("bp_hold_pc", out_pc, 32'h30);
        check_val("bp_hold_src", out_from_lsq, 0);
        mem_pc = 32'h38; mem_data = 32'hD38;
        step();
        check_val("bp_still_full", mem_ready, 0);
        check_val("bp_stable_pc", out_pc, 32'h30);
        check_val("bp_stable_data", out_data, 32'hD30);
        out_ready = 1'b1;
        step();
        check_val("bp_ready_back", mem_ready, 1);
        check_val("bp_rr_lsq_pc", out_pc, 32'h40);
        step();
        mem_valid = 1'b0;
        check_val("bp_order_34", out_pc, 32'h34);
        step();
        check_val("bp_order_38", out_pc, 32'h38);
        step();
        check_val("bp_drained", out_valid, 0);

        // Make LSQ the last grant, fill both queues, then flush with a push
        lsq_valid = 1'b1; lsq_pc = 32'h50; lsq_data = 32'hD50;
        step();
        lsq_valid = 1'b0;
        step();
        out_ready = 1'b0;
        lsq_valid = 1'b1; lsq_pc = 32'h60; mem_valid = 1'b1; mem_pc = 32'h70;
        step();
        lsq_pc = 32'h64; mem_pc = 32'h74;
        step();
        check_val("full_lsq_ready", lsq_ready, 0);
        check_val("full_mem_ready", mem_ready, 0);
        mem_valid = 1'b0;
        flush = 1'b1; lsq_valid = 1'b1; lsq_pc = 32'h77;
        step();
        clear_inputs();
        check_val("flush_valid", out_valid, 0);
        check_val("flush_lsq_ready", lsq_ready, 1);
        check_val("flush_mem_ready", mem_ready, 1);
        check_val("flush_pc", out_pc, 0);
        step();
        check_val("flush_push_absent", out_valid, 0);
        lsq_valid = 1'b1; lsq_pc = 32'h80; mem_valid = 1'b1; mem_pc = 32'h84;
        step();
        clear_inputs();
        check_val("flush_tie_lsq", out_from_lsq, 1);
        check_val("flush_tie_pc", out_pc, 32'h80);
        out_ready = 1'b1;
        step();
        check_val("flush_tie_next", out_pc, 32'h84);
        step();
        check_val("flush_drained", out_valid, 0);

        // Asynchronous reset with two entries queued
        out_ready = 1'b0;
        lsq_valid = 1'b1; lsq_pc = 32'h88; mem_valid = 1'b1; mem_pc = 32'h8C;
        step();
        clear_inputs();
        check_val("arst_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_valid", out_valid, 0);
        check_val("arst_lsq_ready", lsq_ready, 1);
        check_val("arst_mem_ready", mem_ready, 1);
        check_val("arst_pc", out_pc, 0);
        rst = 1'b0;
        mem_valid = 1'b1; mem_pc = 32'h90; mem_data = 32'hD90;
        step();
        mem_valid = 1'b0;
        check_val("arst_after_valid", out_valid, 1);
        check_val("arst_after_src", out_from_lsq, 0);
        check_val("arst_after_pc", out_pc, 32'h90);
        out_ready = 1'b1;
        step();
        check_val("arst_after_drain", out_valid, 0);

        // Random stress against a scoreboard
        wait_l = 0; wait_m = 0; pc_ctr = 32'h0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            check_val("st_valid", out_valid, (lq.size() != 0) || (mq.size() != 0));
            check_val("st_lsq_ready", lsq_ready, lq.size() < DEPTH);
            check_val("st_mem_ready", mem_ready, mq.size() < DEPTH);
            if (out_valid) begin
                if (out_from_lsq) exp_head = (lq.size() != 0) ? lq[0] : ~{out_pc, out_data};
                else              exp_head = (mq.size() != 0) ? mq[0] : ~{out_pc, out_data};
                check_val("st_head", {out_pc, out_data}, exp_head);
            end
            flush     = ($urandom_range(39) == 0);
            lsq_valid = $urandom_range(1) == 1;
            mem_valid = $urandom_range(1) == 1;
            out_ready = $urandom_range(9) < 7;
            pc_ctr    = pc_ctr + 1;
            lsq_pc    = 32'h1000_0000 | pc_ctr;
            mem_pc    = 32'h2000_0000 | pc_ctr;
            lsq_data  = $urandom;
            mem_data  = $urandom;
            pop_l  = out_valid && out_ready && out_from_lsq;
            pop_m  = out_valid && out_ready && !out_from_lsq;
            push_l = lsq_valid && lsq_ready;
            push_m = mem_valid && mem_ready;
            step();
            if (flush) begin
                lq.delete();
                mq.delete();
                wait_l = 0;
                wait_m = 0;
            end else begin
                if (pop_l) begin
                    wait_l = 0;
                    if (mq.size() != 0) wait_m++;
                    check_val("st_fair_mem", wait_m > 1, 0);
                    if (lq.size() != 0) void'(lq.pop_front());
                end
                if (pop_m) begin
                    wait_m = 0;
                    if (lq.size() != 0) wait_l++;
                    check_val("st_fair_lsq", wait_l > 1, 0);
                    if (mq.size() != 0) void'(mq.pop_front());
                end
                if (push_l) lq.push_back({lsq_pc, lsq_data});
                if (push_m) mq.push_back({mem_pc, mem_data});
            end
        end
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
